// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, parity type, legal prescales.
// Pure declarations; no logic, no latency.
// Build option UART_RX_MAJORITY_VOTE_EN (see uart_rx_sampler) does not change anything here.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int PRESCALE_8   = 8;
  localparam int PRESCALE_16  = 16;
  localparam int PRESCALE_32  = 32;
  localparam int PRESCALE_DEF = PRESCALE_8;

  // Only the three supported oversampling ratios are accepted; anything else falls back to the default.
  function automatic logic prescale_legal(input int p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-period timer and bit-value decision for the UART receiver; macro UART_RX_MAJORITY_VOTE_EN.
// Decision strobe at edge_cnt==P/2 (single sample) or P/2+1 (2-of-3 vote when the macro is defined).
// No backpressure: the counter free-runs while i_run is high and holds at 0 otherwise.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rx,
  input  logic                  i_run,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic                  o_sample_bit,
  output logic                  o_sample_strobe,
  output logic                  o_bit_end
);

  logic [PRESCALE_W-1:0] r_edge_cnt;
  logic [PRESCALE_W-1:0] w_half;
  logic [PRESCALE_W-1:0] w_last;

  assign w_half    = i_prescale >> 1;
  assign w_last    = i_prescale - PRESCALE_W'(1);
  assign o_bit_end = i_run && (r_edge_cnt == w_last);

  // Position within the current bit period; parked at 0 whenever no frame is in progress.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_run) begin
      r_edge_cnt <= '0;
    end else if (o_bit_end) begin
      r_edge_cnt <= '0;
    end else begin
      r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic r_vote0;
  logic r_vote1;

  // Capture the two samples preceding the decision cycle; the third is the live line value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vote0 <= 1'b1;
      r_vote1 <= 1'b1;
    end else if (i_run) begin
      if (r_edge_cnt == (w_half - PRESCALE_W'(1))) r_vote0 <= i_rx;
      if (r_edge_cnt == w_half)                    r_vote1 <= i_rx;
    end
  end

  assign o_sample_strobe = i_run && (r_edge_cnt == (w_half + PRESCALE_W'(1)));
  assign o_sample_bit    = (r_vote0 & r_vote1) | (r_vote0 & i_rx) | (r_vote1 & i_rx);
`else
  assign o_sample_strobe = i_run && (r_edge_cnt == w_half);
  assign o_sample_bit    = i_rx;
`endif

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: start detect, LSB-first deserialize, optional parity, stop check; macro UART_RX_MAJORITY_VOTE_EN.
// Pulses (data_valid/par_err/stp_err) appear one cycle after the stop-bit decision, mid stop bit.
// No backpressure: each completed frame is presented once; the consumer must take it on the pulse.
module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  rx_state_t             r_state;
  logic [PRESCALE_W-1:0] r_prescale;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic [3:0]            r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_bad;
  logic [DATA_WIDTH-1:0] r_p_data;
  logic                  r_data_valid;
  logic                  r_par_err;
  logic                  r_stp_err;

  logic w_run;
  logic w_bit;
  logic w_strobe;
  logic w_bit_end;
  logic w_par_exp;

  // The bit timer only runs while a frame is being received.
  assign w_run     = (r_state != ST_IDLE) && (r_state != ST_WAIT_IDLE);
  assign w_par_exp = (^r_shift) ^ (r_par_typ == PAR_ODD);

  uart_rx_sampler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_sampler (
    .i_clk          (CLK),
    .i_rst          (RST),
    .i_rx           (RX_IN),
    .i_run          (w_run),
    .i_prescale     (r_prescale),
    .o_sample_bit   (w_bit),
    .o_sample_strobe(w_strobe),
    .o_bit_end      (w_bit_end)
  );

  // Frame FSM with registered outputs; pulse outputs default low every cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_prescale   <= PRESCALE_W'(PRESCALE_DEF);
      r_par_en     <= 1'b0;
      r_par_typ    <= PAR_EVEN;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par_bad    <= 1'b0;
      r_p_data     <= '0;
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!RX_IN) begin
            r_state    <= ST_START;
            r_prescale <= prescale_legal(int'(PRESCALE)) ? PRESCALE : PRESCALE_W'(PRESCALE_DEF);
            r_par_en   <= PAR_EN;
            r_par_typ  <= PAR_TYP;
            r_bit_cnt  <= '0;
            r_par_bad  <= 1'b0;
          end
        end
        ST_START: begin
          // A start bit that reads high at the decision point was line noise.
          if (w_strobe && w_bit) begin
            r_state <= ST_IDLE;
          end else if (w_bit_end) begin
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_strobe) begin
            r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
          end
          if (w_bit_end) begin
            if (r_bit_cnt == 4'(DATA_WIDTH - 1)) begin
              r_state <= r_par_en ? ST_PARITY : ST_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (w_strobe) begin
            r_par_bad <= (w_bit != w_par_exp);
          end
          if (w_bit_end) begin
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          // Finish at the decision so the next start bit can follow immediately.
          if (w_strobe) begin
            if (w_bit) begin
              r_state <= ST_IDLE;
              if (r_par_bad) begin
                r_par_err <= 1'b1;
              end else begin
                r_p_data     <= r_shift;
                r_data_valid <= 1'b1;
              end
            end else begin
              r_state   <= ST_WAIT_IDLE;
              r_stp_err <= 1'b1;
              r_par_err <= r_par_bad;
            end
          end
        end
        ST_WAIT_IDLE: begin
          // A held-low line (break) must not be mistaken for a string of start bits.
          if (RX_IN) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign P_DATA     = r_p_data;
  assign data_valid = r_data_valid;
  assign par_err    = r_par_err;
  assign stp_err    = r_stp_err;

endmodule
